// File: rtl/fetch_unit.sv
// Instruction fetch stage: next-PC select, single-outstanding imem handshake, 2-entry decode queue.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned PC pushes a fault entry instead of fetching.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0008,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] pc_new,
    output logic        fetch_stall,
    input  logic        halt_active,
    input  logic        reset_stages,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_fault,
    output logic        halt_quiet
);
    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

    state_e      state_q, state_d;
    logic        outstanding_q, outstanding_d;
    logic        drop_q, drop_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;

    logic [31:0] fifo_pc_q    [2];
    logic [31:0] fifo_instr_q [2];

    logic        flush;
    logic        space_ok;
    logic        accept;
    logic        rsp_in;
    logic        push;
    logic        pop;
    logic        mis_push;
    logic        mis_block;
    logic [31:0] push_pc;
    logic [31:0] push_instr;

    assign flush    = branch_taken || reset_stages;
    assign space_ok = ({1'b0, count_q} + {2'b00, outstanding_q}) < 3'd2;
    assign accept   = imem_req && imem_gnt;
    assign rsp_in   = (state_q == S_WAIT) && imem_rvalid;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic mis_lock_q, mis_lock_d;
    logic fifo_fault_q [2];

    // Once a fault entry is queued, stay parked until the pipeline redirects us.
    assign mis_block = (pc[1:0] != 2'b00) || mis_lock_q;
    assign mis_push  = (state_q == S_IDLE) && (pc[1:0] != 2'b00) && !mis_lock_q
                       && space_ok && !halt_active && !flush && !reset;

    always_comb begin
        mis_lock_d = mis_lock_q;
        if (flush)
            mis_lock_d = 1'b0;
        else if (mis_push)
            mis_lock_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            mis_lock_q <= 1'b0;
        else
            mis_lock_q <= mis_lock_d;
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_fault_q[wr_ptr_q] <= mis_push;
    end

    assign push_pc    = mis_push ? pc : req_pc_q;
    assign push_instr = mis_push ? NOP_INSTR : imem_rdata;
    assign id_fault   = id_valid ? fifo_fault_q[rd_ptr_q] : 1'b0;
`else
    assign mis_block  = 1'b0;
    assign mis_push   = 1'b0;
    assign push_pc    = req_pc_q;
    assign push_instr = imem_rdata;
    assign id_fault   = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_WAIT;
            S_WAIT:  if (imem_rvalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        imem_req = 1'b0;
        if (state_q == S_IDLE)
            imem_req = !reset && !halt_active && space_ok && !flush && !mis_block;
    end

    always_comb begin
        pc_new      = pc;
        fetch_stall = 1'b1;
        if (reset) begin
            pc_new      = RESET_PC;
            fetch_stall = 1'b1;
        end else if (branch_taken) begin
            pc_new      = branch_target;
            fetch_stall = 1'b0;
        end else if (accept) begin
            pc_new      = pc + 32'd4;
            fetch_stall = 1'b0;
        end
    end

    assign imem_addr = pc;

    // A flush kills the queue contents and any response arriving in the same cycle.
    assign push = (rsp_in && !drop_q && !flush) || mis_push;
    assign pop  = id_valid && id_ready && !flush;

    always_comb begin
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        req_pc_d      = req_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (accept) begin
            outstanding_d = 1'b1;
            req_pc_d      = pc;
        end else if (rsp_in) begin
            outstanding_d = 1'b0;
        end

        if (rsp_in)
            drop_d = 1'b0;
        else if (flush && outstanding_q)
            drop_d = 1'b1;

        if (flush) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            count_d  = count_q + {1'b0, push} - {1'b0, pop};
            rd_ptr_d = rd_ptr_q ^ pop;
            wr_ptr_d = wr_ptr_q ^ push;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            req_pc_q      <= 32'd0;
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            req_pc_q      <= req_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= push_pc;
            fifo_instr_q[wr_ptr_q] <= push_instr;
        end
    end

    assign id_valid   = (count_q != 2'd0);
    assign id_instr   = id_valid ? fifo_instr_q[rd_ptr_q] : NOP_INSTR;
    assign id_pc      = id_valid ? fifo_pc_q[rd_ptr_q] : 32'd0;
    assign halt_quiet = halt_active && !outstanding_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small PC counter model and hand-computed expectations.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] pc_new;
    logic        fetch_stall;
    logic        halt_active;
    logic        reset_stages;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_fault;
    logic        halt_quiet;

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .pc_new       (pc_new),
        .fetch_stall  (fetch_stall),
        .halt_active  (halt_active),
        .reset_stages (reset_stages),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_fault     (id_fault),
        .halt_quiet   (halt_quiet)
    );

    // Program counter register with stall, as it sits outside the fetch stage.
    always @(posedge clk) begin
        if (reset || !fetch_stall)
            pc <= pc_new;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rd, input logic rdy);
        imem_gnt    = gnt;
        imem_rvalid = rv;
        imem_rdata  = rd;
        id_ready    = rdy;
        #1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; halt_active = 1'b0; reset_stages = 1'b0;
        branch_taken = 1'b0; branch_target = 32'd0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0; id_ready = 1'b1;
        step; step;

        // reset values
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        check_eq("rst_imem_req", imem_req, 0);
        check_eq("rst_id_valid", id_valid, 0);
        check_eq("rst_id_instr", id_instr, NOP);
        check_eq("rst_id_pc", id_pc, 0);
        check_eq("rst_id_fault", id_fault, 0);
        check_eq("rst_halt_quiet", halt_quiet, 0);
        check_eq("rst_pc_new", pc_new, 32'h8);
        check_eq("rst_stall", fetch_stall, 1);
        step;

        // stream: 0xA @8, 0xB @12
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        check_eq("s_req0", imem_req, 1);
        check_eq("s_addr0", imem_addr, 32'h8);
        check_eq("s_pcnew0", pc_new, 32'd12);
        check_eq("s_stall0", fetch_stall, 0);
        step;
        drive(1'b0, 1'b1, 32'hA, 1'b1);
        check_eq("s_req_wait", imem_req, 0);
        check_eq("s_nobypass", id_valid, 0);
        step;
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        check_eq("s_valid_a", id_valid, 1);
        check_eq("s_instr_a", id_instr, 32'hA);
        check_eq("s_pc_a", id_pc, 32'd8);
        check_eq("s_pcnew1", pc_new, 32'd16);
        step;
        drive(1'b0, 1'b1, 32'hB, 1'b1);
        step;
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("s_instr_b", id_instr, 32'hB);
        check_eq("s_pc_b", id_pc, 32'd12);
        step;

        // backpressure: two fetches fill the queue, third is held
        drive(1'b1, 1'b0, 32'd0, 1'b0); step;
        drive(1'b0, 1'b1, 32'hC1, 1'b0); step;
        drive(1'b1, 1'b0, 32'd0, 1'b0);
        check_eq("bp_req_cnt1", imem_req, 1);
        step;
        drive(1'b0, 1'b1, 32'hC2, 1'b0); step;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'd0, 1'b0);
            check_eq("bp_req_full", imem_req, 0);
            check_eq("bp_stall_full", fetch_stall, 1);
            check_eq("bp_head_pc", id_pc, 32'd16);
            step;
        end
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        check_eq("bp_head_c1", id_instr, 32'hC1);
        check_eq("bp_req_popcyc", imem_req, 0);
        step;
        drive(1'b1, 1'b0, 32'd0, 1'b0);
        check_eq("bp_head_c2", id_instr, 32'hC2);
        check_eq("bp_head_c2pc", id_pc, 32'd20);
        check_eq("bp_req_after", imem_req, 1);
        check_eq("bp_addr_after", imem_addr, 32'd24);
        step;
        drive(1'b0, 1'b1, 32'hC3, 1'b0); step;
        drive(1'b0, 1'b0, 32'd0, 1'b1); step;
        drive(1'b1, 1'b0, 32'd0, 1'b0); step;

        // redirect while a response is in flight, one entry queued
        branch_taken = 1'b1; branch_target = 32'h100;
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("br_pcnew", pc_new, 32'h100);
        check_eq("br_stall", fetch_stall, 0);
        check_eq("br_req", imem_req, 0);
        step;
        branch_taken = 1'b0;
        drive(1'b0, 1'b1, 32'hDEAD, 1'b1);
        check_eq("br_flushed", id_valid, 0);
        check_eq("br_req_wait", imem_req, 0);
        step;
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        check_eq("br_dropped", id_valid, 0);
        check_eq("br_req_new", imem_req, 1);
        check_eq("br_addr_new", imem_addr, 32'h100);
        step;
        drive(1'b0, 1'b1, 32'hC0DE, 1'b0); step;
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("br_first_pc", id_pc, 32'h100);
        check_eq("br_first_instr", id_instr, 32'hC0DE);
        step;

        // halt during WAIT
        drive(1'b1, 1'b0, 32'd0, 1'b1); step;
        halt_active = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("h_quiet_wait", halt_quiet, 0);
        step;
        drive(1'b0, 1'b1, 32'h55, 1'b1);
        check_eq("h_quiet_rv", halt_quiet, 0);
        step;
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        check_eq("h_quiet_after", halt_quiet, 1);
        check_eq("h_no_req", imem_req, 0);
        check_eq("h_drain_valid", id_valid, 1);
        check_eq("h_drain_instr", id_instr, 32'h55);
        check_eq("h_stall", fetch_stall, 1);
        step;
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        check_eq("h_drained", id_valid, 0);
        check_eq("h_no_req2", imem_req, 0);
        step;
        halt_active = 1'b0;

        // synchronous reset mid-WAIT with one entry queued
        drive(1'b1, 1'b0, 32'd0, 1'b0); step;
        drive(1'b0, 1'b1, 32'h66, 1'b0); step;
        drive(1'b1, 1'b0, 32'd0, 1'b0); step;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        check_eq("r_pcnew", pc_new, 32'h8);
        check_eq("r_stall", fetch_stall, 1);
        check_eq("r_req", imem_req, 0);
        step;
        reset = 1'b0;
        drive(1'b0, 1'b1, 32'h77, 1'b0);
        check_eq("r_valid", id_valid, 0);
        check_eq("r_instr", id_instr, NOP);
        check_eq("r_idpc", id_pc, 0);
        check_eq("r_fault", id_fault, 0);
        check_eq("r_quiet", halt_quiet, 0);
        step;
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        check_eq("r_late_ignored", id_valid, 0);
        step;

        // PC wrap at the top of the address space
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        drive(1'b0, 1'b0, 32'd0, 1'b1); step;
        branch_taken = 1'b0;
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        check_eq("w_addr", imem_addr, 32'hFFFF_FFFC);
        check_eq("w_pcnew", pc_new, 32'd0);
        step;
        drive(1'b0, 1'b1, 32'h88, 1'b1); step;
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("w_idpc", id_pc, 32'hFFFF_FFFC);
        check_eq("w_instr", id_instr, 32'h88);
        step;

        // misaligned PC
        branch_taken = 1'b1; branch_target = 32'h102;
        drive(1'b0, 1'b0, 32'd0, 1'b0); step;
        branch_taken = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        drive(1'b1, 1'b0, 32'd0, 1'b0);
        check_eq("m_no_req", imem_req, 0);
        check_eq("m_stall", fetch_stall, 1);
        step;
        drive(1'b1, 1'b0, 32'd0, 1'b0);
        check_eq("m_valid", id_valid, 1);
        check_eq("m_fault", id_fault, 1);
        check_eq("m_idpc", id_pc, 32'h102);
        check_eq("m_instr", id_instr, NOP);
        check_eq("m_no_req2", imem_req, 0);
        check_eq("m_pc_hold", pc_new, 32'h102);
        step;
        branch_taken = 1'b1; branch_target = 32'h200;
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        check_eq("m_redir_stall", fetch_stall, 0);
        step;
        branch_taken = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        check_eq("m_cleared", id_valid, 0);
        check_eq("m_req_resume", imem_req, 1);
        check_eq("m_addr_resume", imem_addr, 32'h200);
        step;
`else
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        check_eq("m_req_normal", imem_req, 1);
        check_eq("m_addr", imem_addr, 32'h102);
        check_eq("m_no_fault", id_fault, 0);
        check_eq("m_empty", id_valid, 0);
        step;
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction fetch stage between the program counter register and the decode stage.
- Each cycle it computes the next PC and drives the counter's stall input.
- It issues single-outstanding requests to instruction memory with a request/grant/response handshake.
- It buffers returned instructions in a 2-entry queue for decode, and handles branch redirects, stage flushes and debugger halts.

## Interface
Parameters:
- RESET_PC, 32'h00000008, counter reset value; drives pc_new during reset.
- NOP_INSTR, 32'h00000013, value on id_instr when the queue is empty.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  32  current program counter.
- pc_new  out  32  next PC to the counter.
- fetch_stall  out  1  to the counter's Stall; 1 means hold the PC.
- halt_active  in  1  debugger halt; blocks new requests.
- reset_stages  in  1  pipeline flush.
- branch_taken  in  1  redirect request from execute.
- branch_target  in  32  redirect address.
- imem_req  out  1  fetch request.
- imem_addr  out  32  request address; always equals pc.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  response instruction.
- id_valid  out  1  queue head valid to decode.
- id_ready  in  1  decode accepts the head.
- id_instr  out  32  head instruction.
- id_pc  out  32  head PC.
- id_fault  out  1  head is a misaligned-fetch fault (see Configuration).
- halt_quiet  out  1  halted, with no request outstanding.

## Operation
- State:
  - 2-entry FIFO of {pc, instr, fault}; count is 0..2.
  - outstanding flag; drop flag.
  - FSM states: IDLE and WAIT.
- IDLE:
  - imem_req = !halt_active && (count + outstanding < 2) && !branch_taken && !reset_stages.
  - On imem_req && imem_gnt: set outstanding, store the request PC, go to WAIT.
- WAIT:
  - imem_req = 0.
  - On imem_rvalid: clear outstanding and return to IDLE.
  - Push {stored pc, imem_rdata, 0} unless drop is set. If drop is set, discard the response and clear drop.
- Next-PC rules, combinational, in priority order:
  - reset: pc_new = RESET_PC, fetch_stall = 1.
  - branch_taken: pc_new = branch_target, fetch_stall = 0.
  - Accepted request (imem_req && imem_gnt): pc_new = pc + 4 (modulo 2^32, so 32'hFFFFFFFC wraps to 0), fetch_stall = 0.
  - Otherwise: pc_new = pc, fetch_stall = 1.
- Flush (branch_taken or reset_stages):
  - Clear the FIFO.
  - If a response is outstanding and does not arrive in this cycle, set drop.
  - A response arriving in the same cycle is discarded.
  - A pop in the same cycle is ignored.
- Simultaneous push and pop at count 2 or 1: allowed, count unchanged. Push at count 2 without a pop cannot occur by construction.
- Output mapping:
  - id_valid = (count != 0).
  - id_instr, id_pc and id_fault come from the head.
  - When empty: id_instr = NOP_INSTR, id_pc = 0, id_fault = 0.
- halt_quiet = halt_active && !outstanding. The queue keeps draining to decode during halt.
- Reset (synchronous, wins over everything):
  - FIFO empty, outstanding = 0, drop = 0, FSM = IDLE.
  - Reset values: imem_req 0, id_valid 0, id_instr NOP_INSTR, id_pc 0, id_fault 0, halt_quiet 0.
  - Reset mid-request abandons the transaction. The memory response after reset is ignored, because outstanding is 0 and WAIT is not active.

## Timing
- The handshake completes in the cycle where imem_req && imem_gnt.
- imem_rvalid arrives at the earliest 1 cycle after the grant; any later cycle is legal.
- imem_req may stay high for several cycles awaiting grant. imem_addr is stable because fetch_stall = 1 until the grant.
- The PC advances on the edge after the grant.
- An instruction is visible on id_valid in the cycle after imem_rvalid; there is no bypass.
- Best-case throughput is one instruction per 2 cycles (single outstanding request).
- A redirect takes effect on the next edge. The first new request can issue in the cycle after the redirect.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - In IDLE with pc[1:0] != 0 and space available, no memory request is issued.
  - Instead, {pc, NOP_INSTR, 1} is pushed, and the unit holds fetch_stall = 1 until branch_taken or reset_stages.
- Undefined: pc[1:0] is ignored, requests issue as normal, and id_fault is tied to 0.

## Test plan
- Reset then stream:
  - Stimulus: pc = 8; gnt is immediate; rvalid arrives 1 cycle after each grant with rdata 0xA, 0xB; id_ready = 1.
  - Required: id_instr = 0xA with id_pc = 8, then 0xB with id_pc = 12; pc_new sequence 12, 16.
- Backpressure:
  - Stimulus: id_ready = 0 with 3 fetches pending.
  - Required: exactly 2 queued; imem_req stays 0 and fetch_stall stays 1 until a pop.
- Redirect with a response in flight:
  - Stimulus: branch_taken with target 0x100 while in WAIT.
  - Required: the late response is dropped, the queue is emptied, the next request has imem_addr = 0x100, and the first id_pc is 0x100.
- Halt:
  - Stimulus: halt_active asserted during WAIT.
  - Required: no new imem_req; halt_quiet rises the cycle after rvalid; the queue still drains.
- Synchronous reset mid-WAIT:
  - Required: all outputs return to their reset values on the next edge, and the later rvalid is ignored (id_valid stays 0).
- With FETCH_MISALIGN_CHECK_EN:
  - Stimulus: pc = 0x102.
  - Required: no imem_req; id_valid = 1, id_fault = 1, id_pc = 0x102, id_instr = NOP_INSTR.
